// File: rtl/onehot_pkg.sv
// onehot_pkg: one-hot validity and lowest-set-bit index helpers, sized for up to 32 states
package onehot_pkg;
  localparam int MAX_N = 32;
  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
  function automatic logic [4:0] onehot_idx(input logic [MAX_N-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = MAX_N - 1; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction
endpackage

// File: rtl/onehot_state_reg_p_enc.sv
// onehot_enc: one-hot to binary index, lowest set bit wins, all-zero gives 0
module onehot_enc
  import onehot_pkg::*;
#(
  parameter int N = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     oh,
  output logic [IDX_W-1:0] idx
);
  assign idx = IDX_W'(onehot_idx(MAX_N'(oh)));
endmodule

// File: rtl/onehot_state_reg_p.sv
// onehot_state_reg_p: parametrised one-hot state register with force, illegal detection/recovery and dwell counter
module onehot_state_reg_p
  import onehot_pkg::*;
#(
  parameter int N = 6,
  parameter int RESET_STATE = 0,
  parameter int RECOVER = 1,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             EN,
  input  logic             FORCE,
  input  logic [IDX_W-1:0] FORCE_IDX,
  input  logic [N-1:0]     nxt_state,
  input  logic             err_clr,
  output logic [N-1:0]     state,
  output logic [IDX_W-1:0] state_idx,
  output logic             changed,
  output logic [CNT_W-1:0] dwell,
  output logic             illegal,
  output logic             err_sticky
);
  localparam logic [N-1:0] RST_OH = N'(1) << RESET_STATE;
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  logic [N-1:0] next;
  logic force_ok, nxt_ok, bad;
  assign force_ok = 32'(FORCE_IDX) < N;
  assign nxt_ok = is_onehot(MAX_N'(nxt_state));
  always_comb begin
    next = FORCE ? (force_ok ? N'(1) << FORCE_IDX : RST_OH)
         : EN ? ((nxt_ok || RECOVER == 0) ? nxt_state : RST_OH)
         : state;
    bad = FORCE ? !force_ok : EN && !nxt_ok;
  end
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state <= RST_OH;
      changed <= 1'b0;
      dwell <= '0;
      illegal <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= next;
      changed <= next != state;
      dwell <= (next != state) ? '0 : (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);
      illegal <= bad;
      err_sticky <= bad | (err_sticky & ~err_clr);
    end
  end
  onehot_enc #(.N(N), .IDX_W(IDX_W)) u_enc (.oh(state), .idx(state_idx));
endmodule

// File: tb/tb_onehot_state_reg_p.sv
// tb_onehot_state_reg_p: table-driven vectors plus hand sequences for reset, RECOVER=0 and dwell saturation
module tb_onehot_state_reg_p;
  logic clk = 0, clrn = 0, en = 0, frc = 0, clr = 0;
  logic [2:0] fidx = 0;
  logic [5:0] nxt = 0;
  logic [5:0] st_a, st_b, st_c;
  logic [2:0] ix_a, ix_b, ix_c;
  logic ch_a, ch_b, ch_c, il_a, il_b, il_c, er_a, er_b, er_c;
  logic [7:0] dw_a, dw_b;
  logic [3:0] dw_c;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  onehot_state_reg_p #(.N(6), .RESET_STATE(2), .RECOVER(1), .CNT_W(8)) u_a (
    .CLK(clk), .CLRN(clrn), .EN(en), .FORCE(frc), .FORCE_IDX(fidx), .nxt_state(nxt), .err_clr(clr),
    .state(st_a), .state_idx(ix_a), .changed(ch_a), .dwell(dw_a), .illegal(il_a), .err_sticky(er_a));
  onehot_state_reg_p #(.N(6), .RESET_STATE(2), .RECOVER(0), .CNT_W(8)) u_b (
    .CLK(clk), .CLRN(clrn), .EN(en), .FORCE(frc), .FORCE_IDX(fidx), .nxt_state(nxt), .err_clr(clr),
    .state(st_b), .state_idx(ix_b), .changed(ch_b), .dwell(dw_b), .illegal(il_b), .err_sticky(er_b));
  onehot_state_reg_p #(.N(6), .RESET_STATE(2), .RECOVER(1), .CNT_W(4)) u_c (
    .CLK(clk), .CLRN(clrn), .EN(en), .FORCE(frc), .FORCE_IDX(fidx), .nxt_state(nxt), .err_clr(clr),
    .state(st_c), .state_idx(ix_c), .changed(ch_c), .dwell(dw_c), .illegal(il_c), .err_sticky(er_c));
  typedef struct {
    logic en, frc;
    logic [2:0] fidx;
    logic [5:0] nxt;
    logic clr;
    logic [5:0] st;
    logic [2:0] idx;
    logic ch;
    logic [7:0] dw;
    logic il, er;
  } vec_t;
  vec_t tv[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic e, input logic f, input logic [2:0] fi, input logic [5:0] n, input logic c);
    en = e; frc = f; fidx = fi; nxt = n; clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    en = 0; frc = 0; fidx = 0; nxt = 0; clr = 0; clrn = 0;
    @(posedge clk);
    @(negedge clk);
    clrn = 1;
  endtask
  initial begin
    tv[0] = '{1, 0, 0, 6'b010000, 0, 6'b010000, 4, 1, 0, 0, 0};
    for (int i = 1; i <= 5; i++) tv[i] = '{0, 0, 0, 6'b000001, 0, 6'b010000, 4, 0, 8'(i), 0, 0};
    tv[6]  = '{1, 0, 0, 6'b000011, 0, 6'b000100, 2, 1, 0, 1, 1};
    tv[7]  = '{0, 0, 0, 6'b000000, 0, 6'b000100, 2, 0, 1, 0, 1};
    tv[8]  = '{1, 0, 0, 6'b001000, 1, 6'b001000, 3, 1, 0, 0, 0};
    tv[9]  = '{1, 1, 5, 6'b000001, 0, 6'b100000, 5, 1, 0, 0, 0};
    tv[10] = '{0, 1, 7, 6'b000000, 0, 6'b000100, 2, 1, 0, 1, 1};
    tv[11] = '{0, 1, 2, 6'b000000, 0, 6'b000100, 2, 0, 1, 0, 1};
    tv[12] = '{1, 0, 0, 6'b000100, 1, 6'b000100, 2, 0, 2, 0, 0};
    tv[13] = '{1, 0, 0, 6'b000000, 0, 6'b000100, 2, 0, 3, 1, 1};
    tv[14] = '{0, 0, 0, 6'b000000, 1, 6'b000100, 2, 0, 4, 0, 0};
    tv[15] = '{0, 1, 0, 6'b000000, 0, 6'b000001, 0, 1, 0, 0, 0};
    tv[16] = '{1, 0, 0, 6'b100000, 0, 6'b100000, 5, 1, 0, 0, 0};
    do_reset();
    #1;
    chk("rst_state", 32'(st_a), 32'b000100);
    chk("rst_idx", 32'(ix_a), 2);
    chk("rst_dwell", 32'(dw_a), 0);
    chk("rst_err", 32'(er_a), 0);
    chk("rst_changed", 32'(ch_a), 0);
    chk("rst_illegal", 32'(il_a), 0);
    for (int i = 0; i < 17; i++) begin
      step(tv[i].en, tv[i].frc, tv[i].fidx, tv[i].nxt, tv[i].clr);
      chk($sformatf("v%0d_state", i), 32'(st_a), 32'(tv[i].st));
      chk($sformatf("v%0d_idx", i), 32'(ix_a), 32'(tv[i].idx));
      chk($sformatf("v%0d_changed", i), 32'(ch_a), 32'(tv[i].ch));
      chk($sformatf("v%0d_dwell", i), 32'(dw_a), 32'(tv[i].dw));
      chk($sformatf("v%0d_illegal", i), 32'(il_a), 32'(tv[i].il));
      chk($sformatf("v%0d_err", i), 32'(er_a), 32'(tv[i].er));
    end
    en = 0; frc = 0; clr = 0;
    #2 clrn = 0;
    #1;
    chk("async_state", 32'(st_a), 32'b000100);
    chk("async_dwell", 32'(dw_a), 0);
    chk("async_changed", 32'(ch_a), 0);
    #1 clrn = 1;
    step(0, 0, 0, 6'b100000, 0);
    chk("post_async_state", 32'(st_a), 32'b000100);
    chk("post_async_dwell", 32'(dw_a), 1);
    do_reset();
    step(1, 0, 0, 6'b000000, 0);
    chk("r0_state", 32'(st_b), 0);
    chk("r0_idx", 32'(ix_b), 0);
    chk("r0_illegal", 32'(il_b), 1);
    chk("r0_err", 32'(er_b), 1);
    chk("r0_changed", 32'(ch_b), 1);
    step(1, 0, 0, 6'b000110, 1);
    chk("r0_two_state", 32'(st_b), 32'b000110);
    chk("r0_two_idx", 32'(ix_b), 1);
    chk("r0_two_illegal", 32'(il_b), 1);
    chk("r0_setwins_err", 32'(er_b), 1);
    step(0, 0, 0, 6'b000000, 0);
    chk("r0_hold_illegal", 32'(il_b), 0);
    chk("r0_hold_err", 32'(er_b), 1);
    step(0, 0, 0, 6'b000000, 1);
    chk("r0_clr_err", 32'(er_b), 0);
    do_reset();
    step(1, 0, 0, 6'b000001, 0);
    chk("sat_start", 32'(dw_c), 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 6'b000010, 0);
      chk($sformatf("sat_dwell%0d", i), 32'(dw_c), (i > 15) ? 15 : i);
    end
    step(1, 0, 0, 6'b000010, 0);
    chk("sat_change_dwell", 32'(dw_c), 0);
    chk("sat_change_ch", 32'(ch_c), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
